// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between a host controller and the PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;

  modport master (output tx_data, tx_start,
                  input  tx_busy, tx_done, tx_error, rx_inhibit);
  modport slave  (input  tx_data, tx_start,
                  output tx_busy, tx_done, tx_error, rx_inhibit);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 10 bits on
// device clock falls, then check the device ACK and wait for idle lines.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clock,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_drive_low,
  output logic         ps2_data_drive_low
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

  state_t        state;
  logic [IW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [3:0]    idx;
  logic [9:0]    frame;
  logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic          busy, done_q, err_q;
  logic          fall;

  assign fall          = clk_prev & ~clk_s2;
  assign tx.tx_busy    = busy;
  assign tx.rx_inhibit = busy;
  assign tx.tx_done    = done_q;
  assign tx.tx_error   = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      tmo                <= '0;
      idx                <= '0;
      frame              <= '0;
      // Sync chain starts at the idle-high line level so no phantom fall appears.
      clk_s1             <= 1'b1;
      clk_s2             <= 1'b1;
      clk_prev           <= 1'b1;
      data_s1            <= 1'b1;
      data_s2            <= 1'b1;
      busy               <= 1'b0;
      done_q             <= 1'b0;
      err_q              <= 1'b0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx.tx_start) begin
            frame              <= {1'b1, ~^tx.tx_data, tx.tx_data};
            cnt                <= '0;
            busy               <= 1'b1;
            ps2_clk_drive_low  <= 1'b1;
            ps2_data_drive_low <= 1'b0;
            state              <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            ps2_data_drive_low <= 1'b1;
            state              <= REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REQ: begin
          ps2_clk_drive_low <= 1'b0;
          idx               <= '0;
          tmo               <= '0;
          state             <= SHIFT;
        end
        default: begin
          // SHIFT, ACK and WAIT_IDLE share one watchdog; it wins over a fall.
          tmo <= tmo + 1'b1;
          if (tmo == TMO_LAST) begin
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            err_q              <= 1'b1;
            busy               <= 1'b0;
            state              <= IDLE;
          end else begin
            case (state)
              SHIFT: begin
                if (fall) begin
                  ps2_data_drive_low <= ~frame[idx];
                  idx                <= idx + 4'd1;
                  if (idx == 4'd9) state <= ACK;
                end
              end
              ACK: begin
                if (fall) begin
                  if (data_s2) begin
                    ps2_data_drive_low <= 1'b0;
                    err_q              <= 1'b1;
                    busy               <= 1'b0;
                    state              <= IDLE;
                  end else begin
                    state <= WAIT_IDLE;
                  end
                end
              end
              WAIT_IDLE: begin
                if (clk_s2 && data_s2) begin
                  done_q <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a clocking PS/2 device model.
module tb_ps2_host_tx;
  localparam int HALF = 40;

  logic clock = 1'b0;
  logic reset;
  logic ps2_clk_drive_low, ps2_data_drive_low;
  logic dev_clk_low, dev_data_low;
  logic ps2_clk_w, ps2_data_w;

  ps2_host_tx_if ifc();

  assign ps2_clk_w  = ~(ps2_clk_drive_low  | dev_clk_low);
  assign ps2_data_w = ~(ps2_data_drive_low | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(2000)) dut (
    .clock              (clock),
    .reset              (reset),
    .tx                 (ifc),
    .ps2_clk_in         (ps2_clk_w),
    .ps2_data_in        (ps2_data_w),
    .ps2_clk_drive_low  (ps2_clk_drive_low),
    .ps2_data_drive_low (ps2_data_drive_low)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, track_bad = 0, both_bad = 0;
  logic [1:0] post_err_drv = 2'b11;
  logic err_prev = 1'b0;
  logic [10:0] dev_bits;
  bit dev_ok;
  int fall11_cyc = 0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (!reset) begin
      if (ifc.tx_busy !== ifc.rx_inhibit) track_bad++;
      if (ifc.tx_done && ifc.tx_error) both_bad++;
    end
    if (ifc.tx_done) done_cnt++;
    if (ifc.tx_error) begin err_cnt++; err_cyc = cyc; end
    if (err_prev) post_err_drv = {ps2_clk_drive_low, ps2_data_drive_low};
    err_prev = ifc.tx_error;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clock); ifc.tx_data = d; ifc.tx_start = 1'b1;
    @(negedge clock); ifc.tx_start = 1'b0;
  endtask

  // Device: reads start bit once the host releases clock, then 10 clocks
  // sampled on rising edges, then an ACK clock (data low if ack).
  task automatic dev_run(input bit ack, input int abort_at);
    int n;
    dev_ok = 1'b1; dev_bits = '0; n = 0;
    while (!(ps2_clk_drive_low == 1'b0 && ps2_data_w == 1'b0) && n < 200) begin
      @(negedge clock); n++;
    end
    if (n >= 200) begin dev_ok = 1'b0; return; end
    dev_bits[0] = ps2_data_w;
    for (int i = 1; i <= 10; i++) begin
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b1;
      if (i == abort_at) begin repeat (6) @(negedge clock); return; end
      repeat (HALF) @(negedge clock);
      dev_bits[i] = ps2_data_w;
      dev_clk_low = 1'b0;
    end
    repeat (HALF/2) @(negedge clock);
    if (ack) dev_data_low = 1'b1;
    repeat (HALF/2) @(negedge clock);
    dev_clk_low = 1'b1; fall11_cyc = cyc;
    repeat (HALF) @(negedge clock);
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
  endtask

  task automatic finish_checks(input string nm, input bit ack, input logic [10:0] ef,
                               input int d0, input int e0);
    int n;
    n = 0;
    while (ifc.tx_busy && n < 200) begin @(negedge clock); n++; end
    repeat (5) @(negedge clock);
    chk({nm, "_sync"}, 32'(dev_ok), 1);
    chk({nm, "_frame"}, 32'(dev_bits), 32'(ef));
    chk({nm, "_done"}, done_cnt - d0, 32'(ack));
    chk({nm, "_err"}, err_cnt - e0, 32'(!ack));
    chk({nm, "_idle"}, {29'd0, ifc.tx_busy, ps2_clk_drive_low, ps2_data_drive_low}, 0);
  endtask

  task automatic run_vec(input logic [7:0] d, input bit ack, input logic [10:0] ef,
                         input string nm);
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(d);
    dev_run(ack, 0);
    finish_checks(nm, ack, ef, d0, e0);
    if (!ack) begin
      chk({nm, "_errlat"}, 32'((err_cyc - fall11_cyc) inside {[2:4]}), 1);
      chk({nm, "_reldrv"}, 32'(post_err_drv), 0);
    end
  endtask

  typedef struct {
    logic [7:0]  d;
    bit          ack;
    logic [10:0] frame;   // {stop, parity, D7..D0, start} as seen by the device
    string       nm;
  } vec_t;

  vec_t tv[6];

  initial begin
    int n, d0, e0;
    tv[0] = '{8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, "ed"};
    tv[1] = '{8'h00, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, "noack00"};
    tv[2] = '{8'h55, 1'b1, {1'b1, 1'b1, 8'h55, 1'b0}, "v55"};
    tv[3] = '{8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, "vff"};
    tv[4] = '{8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, "v01"};
    tv[5] = '{8'h07, 1'b1, {1'b1, 1'b0, 8'h07, 1'b0}, "v07"};

    reset = 1'b1; ifc.tx_start = 1'b0; ifc.tx_data = '0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_outs", {26'd0, ifc.tx_busy, ifc.tx_done, ifc.tx_error, ifc.rx_inhibit,
                       ps2_clk_drive_low, ps2_data_drive_low}, 0);

    foreach (tv[i]) run_vec(tv[i].d, tv[i].ack, tv[i].frame, tv[i].nm);

    // Inhibit / request-to-send timing.
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clock); ifc.tx_data = 8'h12; ifc.tx_start = 1'b1;
    @(negedge clock); ifc.tx_start = 1'b0;
    n = 0;
    while (ps2_clk_drive_low && !ps2_data_drive_low && n < 50) begin
      n++; @(negedge clock);
    end
    chk("inhibit_len", n, 8);
    chk("req_lines", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'b11);
    @(negedge clock);
    chk("after_req", {30'd0, ps2_clk_drive_low, ps2_data_drive_low}, 32'b01);
    dev_run(1'b1, 0);
    finish_checks("v12", 1'b1, {1'b1, 1'b1, 8'h12, 1'b0}, d0, e0);

    // Device never clocks: watchdog fires 2000 cycles after REQ.
    e0 = err_cnt;
    pulse_start(8'h3C);
    n = 0;
    while (ps2_clk_drive_low && n < 100) begin @(negedge clock); n++; end
    n = 0;
    while (!ifc.tx_error && n < 3000) begin @(negedge clock); n++; end
    chk("timeout_len", n, 2000);
    chk("timeout_idle", 32'(ifc.tx_busy), 0);
    @(negedge clock);
    chk("timeout_rel", {29'd0, ifc.tx_busy, ps2_clk_drive_low, ps2_data_drive_low}, 0);
    chk("timeout_err", err_cnt - e0, 1);

    // Second request while busy is dropped.
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(8'h55);
    fork
      dev_run(1'b1, 0);
      begin
        repeat (100) @(negedge clock);
        chk("busy_at_2nd", 32'(ifc.tx_busy), 1);
        pulse_start(8'hAA);
      end
    join
    finish_checks("busy55", 1'b1, {1'b1, 1'b1, 8'h55, 1'b0}, d0, e0);
    repeat (30) @(negedge clock);
    chk("no_queue", {30'd0, ifc.tx_busy, ps2_clk_drive_low}, 0);

    // Reset after the 4th fall, then a clean send.
    pulse_start(8'h00);
    dev_run(1'b1, 4);
    chk("pre_rst", {30'd0, ifc.tx_busy, ps2_data_drive_low}, 32'b11);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_outs", {26'd0, ifc.tx_busy, ifc.tx_done, ifc.tx_error, ifc.rx_inhibit,
                         ps2_clk_drive_low, ps2_data_drive_low}, 0);
    dev_clk_low = 1'b0;
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    run_vec(8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, "ff_after_rst");

    chk("busy_tracks_inhibit", track_bad, 0);
    chk("done_err_exclusive", both_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule
